// File: rtl/control_fsm_if.sv
// Instruction handshake, memory status and datapath control bundle for control_fsm.
// No logic of its own; the control block drives every control output.
// ready is the only flow-control signal and is high only while the block is idle.
interface control_fsm_if #(
    parameter int OP_W  = 6,
    parameter int ALU_W = 4
);
    logic [OP_W-1:0]  op;
    logic             instr_valid;
    logic             ready;
    logic             zero;
    logic             mem_ready;
    logic             reg_dest;
    logic             alu_src;
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             pc_write;
    logic [ALU_W-1:0] alu_ctrl;
    logic             sys_op;
    logic             illegal;
    logic             mem_err;
    logic             done;

    // instruction source / memory model / control consumer side
    modport master (
        output op, instr_valid, zero, mem_ready,
        input  ready, reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, pc_write, alu_ctrl, sys_op, illegal, mem_err, done
    );

    // control unit side
    modport slave (
        input  op, instr_valid, zero, mem_ready,
        output ready, reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, pc_write, alu_ctrl, sys_op, illegal, mem_err, done
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle instruction control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB).
// Latency acceptance-to-done: illegal 1, branch/sys 2, ALU 3, store 3+wait, load 4+wait.
// Accepts one instruction at a time (ready only in IDLE); MEM waits on mem_ready up to TIMEOUT cycles.
module control_fsm #(
    parameter int OP_W    = 6,
    parameter int ALU_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    control_fsm_if.slave  bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LBD   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LDW   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_STB   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_STW   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_MOV   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(21);
    localparam logic [OP_W-1:0] OP_TLBW  = OP_W'(30);
    localparam logic [OP_W-1:0] OP_IRET  = OP_W'(31);
    localparam logic [OP_W-1:0] OP_R_END = OP_W'(5);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    function automatic logic is_rtype(input logic [OP_W-1:0] o);
        return o < OP_R_END;
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] o);
        return (o == OP_LBD) || (o == OP_LDW);
    endfunction

    // MOV is routed through MEM as a write access, so it classes with the stores
    function automatic logic is_store(input logic [OP_W-1:0] o);
        return (o == OP_STB) || (o == OP_STW) || (o == OP_MOV);
    endfunction

    function automatic logic is_sys(input logic [OP_W-1:0] o);
        return (o == OP_TLBW) || (o == OP_IRET);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] o);
        return is_rtype(o) || (o == OP_ADDI) || is_load(o) || is_store(o) ||
               (o == OP_BEQ) || (o == OP_JUMP) || is_sys(o);
    endfunction

    function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] o);
        if (is_rtype(o))    return ALU_W'(o);
        if (o == OP_BEQ)    return ALU_W'(1);
        return '0;
    endfunction

    state_t           state, state_n;
    logic [OP_W-1:0]  op_q, op_n;
    logic [CW-1:0]    wait_cnt;
    logic             timeout;

    logic             ready_q, reg_dest_q, alu_src_q, mem_to_reg_q, reg_write_q;
    logic             mem_read_q, mem_write_q, branch_q, sys_op_q, illegal_q;
    logic [ALU_W-1:0] alu_ctrl_q;

    // next-state routing, with memory timeout detection
    always_comb begin
        state_n = state;
        op_n    = op_q;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (bus.instr_valid) begin
                    state_n = DECODE;
                    op_n    = bus.op;
                end
            end
            DECODE: state_n = is_legal(op_q) ? EXEC : IDLE;
            EXEC: begin
                if (is_rtype(op_q) || op_q == OP_ADDI)        state_n = WB;
                else if (is_load(op_q) || is_store(op_q))     state_n = MEM;
                else                                          state_n = IDLE;
            end
            MEM: begin
                if (bus.mem_ready) begin
                    state_n = is_load(op_q) ? WB : IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, latched opcode, wait counter and the state-decoded control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= '0;
            wait_cnt     <= '0;
            ready_q      <= 1'b1;
            reg_dest_q   <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            sys_op_q     <= 1'b0;
            illegal_q    <= 1'b0;
            alu_ctrl_q   <= '0;
        end else begin
            state        <= state_n;
            op_q         <= op_n;
            // staying in MEM implies mem_ready was low this cycle
            wait_cnt     <= (state == MEM && state_n == MEM) ? wait_cnt + CW'(1) : '0;
            ready_q      <= (state_n == IDLE);
            illegal_q    <= (state_n == DECODE) && !is_legal(op_n);
            branch_q     <= (state_n == EXEC) && (op_n == OP_BEQ || op_n == OP_JUMP);
            sys_op_q     <= (state_n == EXEC) && is_sys(op_n);
            mem_read_q   <= (state_n == MEM) && is_load(op_n);
            mem_write_q  <= (state_n == MEM) && is_store(op_n);
            reg_write_q  <= (state_n == WB);
            reg_dest_q   <= (state_n == WB) && is_rtype(op_n);
            mem_to_reg_q <= (state_n == WB) && is_load(op_n);
            alu_src_q    <= (state_n == EXEC || state_n == MEM || state_n == WB) &&
                            (op_n == OP_ADDI || is_load(op_n) || is_store(op_n));
            alu_ctrl_q   <= (state_n == EXEC || state_n == MEM || state_n == WB) ?
                            alu_code(op_n) : '0;
        end
    end

    // outputs that react to same-cycle inputs (zero, mem_ready) stay combinational
    assign bus.pc_write   = (state == EXEC) && (op_q == OP_JUMP || (op_q == OP_BEQ && bus.zero));
    assign bus.mem_err    = timeout;
    assign bus.done       = ((state == DECODE) && !is_legal(op_q)) ||
                            ((state == EXEC) && (op_q == OP_BEQ || op_q == OP_JUMP || is_sys(op_q))) ||
                            ((state == MEM) && bus.mem_ready && is_store(op_q)) ||
                            timeout ||
                            (state == WB);

    assign bus.ready      = ready_q;
    assign bus.reg_dest   = reg_dest_q;
    assign bus.alu_src    = alu_src_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.branch     = branch_q;
    assign bus.sys_op     = sys_op_q;
    assign bus.illegal    = illegal_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL expose parameter OP_W, default 6, the opcode width; supported values are 6 to 8.
REQ-002 The block SHALL expose parameter ALU_W, default 4, the alu_ctrl width.
REQ-003 The block SHALL expose parameter TIMEOUT, default 16, the maximum MEM wait in cycles; it SHALL be at least 1.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset: clk in, 1 bit, rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-006 op  in  OP_W  opcode; sampled only on acceptance.
REQ-007 instr_valid  in  1  an instruction is offered on op.
REQ-008 ready  out  1  the block can accept an instruction; high only in IDLE.
REQ-009 zero  in  1  ALU zero flag, sampled in EXEC for BEQ.
REQ-010 mem_ready  in  1  data memory has completed the current access.
REQ-011 reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, pc_write  out  1 each  datapath controls.
REQ-012 alu_ctrl  out  ALU_W  ALU operation select.
REQ-013 sys_op  out  1  one-cycle pulse for TLBWRITE or IRET.
REQ-014 illegal  out  1  one-cycle pulse for an undefined opcode.
REQ-015 mem_err  out  1  one-cycle pulse on a MEM timeout.
REQ-016 done  out  1  one-cycle pulse on the last cycle of every accepted instruction.

Function
REQ-017 Opcodes SHALL be: ADD=0, SUB=1, MUL=2, AND=3, OR=4, ADDI=5, LBD=10, LDW=11, STB=12, STW=13, MOV=14, BEQ=20, JUMP=21, TLBWRITE=30, IRET=31. All other values SHALL be illegal.
REQ-018 The FSM states SHALL be IDLE, DECODE, EXEC, MEM and WB.
REQ-019 An instruction SHALL be accepted when instr_valid && ready. On acceptance op SHALL be latched into op_q, and the next state SHALL be DECODE.
REQ-020 DECODE, illegal op_q: illegal=1 and done=1 for that cycle, then IDLE. Otherwise the next state SHALL be EXEC.
REQ-021 EXEC routing:
- ADD..OR and ADDI SHALL go to WB.
- LBD, LDW, STB, STW and MOV SHALL go to MEM.
- BEQ, JUMP, TLBWRITE and IRET SHALL go to IDLE with done=1.
REQ-022 alu_ctrl SHALL be valid in EXEC, MEM and WB:
- ADD..OR = opcode value.
- ADDI, memory ops = 0.
- BEQ = 1.
- All other cases = 0.
REQ-023 alu_src SHALL be 1 in EXEC, MEM and WB for ADDI and memory ops, and 0 otherwise.
REQ-024 BEQ in EXEC: branch=1, and pc_write=zero.
REQ-025 JUMP in EXEC: branch=1, and pc_write=1.
REQ-026 TLBWRITE or IRET in EXEC: sys_op=1.
REQ-027 In MEM, mem_read SHALL be held high for LBD and LDW, and mem_write SHALL be held high for STB, STW and MOV, until the cycle in which mem_ready=1 (inclusive).
REQ-028 MEM exit on mem_ready=1: loads SHALL go to WB; stores and MOV SHALL go to IDLE with done=1.
REQ-029 A wait counter SHALL clear on MEM entry and increment each MEM cycle in which mem_ready=0.
REQ-030 When the wait counter reaches TIMEOUT, the block SHALL assert mem_err=1 and done=1, drop the request, and go to IDLE with no writeback.
REQ-031 If mem_ready=1 arrives in the same cycle the counter reaches TIMEOUT, mem_ready SHALL win and mem_err SHALL stay 0.
REQ-032 WB SHALL last exactly one cycle: reg_write=1 and done=1, then IDLE.
REQ-033 In WB, reg_dest SHALL be 1 for ADD..OR and 0 otherwise; mem_to_reg SHALL be 1 for loads.
REQ-034 Latency from acceptance to done, inclusive of the done cycle (acceptance cycle is cycle 0):
- R-type/ADDI: done at cycle 3.
- BEQ/JUMP/sys: done at cycle 2.
- Store with mem_ready on the first MEM cycle: done at cycle 3.
- Load with mem_ready on the first MEM cycle: done at cycle 4.
- Illegal: done at cycle 1.
REQ-035 Each control output SHALL be 0 in every state and case not listed above.
REQ-036 instr_valid SHALL be ignored while not in IDLE. op changes after acceptance SHALL have no effect.

Reset
REQ-037 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear op_q and the wait counter.
REQ-038 After that edge, every output SHALL be 0 except ready=1.
REQ-039 Reset asserted in any state, including mid-MEM, SHALL abort the instruction with no done, mem_err or reg_write pulse.
REQ-040 Reset SHALL take priority over every other input.

Verification
REQ-041 A bench SHALL cover: op=1 (SUB) accepted -> alu_ctrl=1 in EXEC; reg_dest=1 and reg_write=1 in WB; done at cycle 3.
REQ-042 A bench SHALL cover: op=11 (LDW), mem_ready low 3 MEM cycles then high -> mem_read high 4 cycles; WB with mem_to_reg=1 and reg_write=1.
REQ-043 A bench SHALL cover: op=13 (STW), mem_ready never high, TIMEOUT=16 -> mem_err and done together on the 16th MEM cycle; reg_write never 1.
REQ-044 A bench SHALL cover: op=20 (BEQ), once with zero=1 and once with zero=0 -> pc_write=1 and 0 respectively, with branch=1 in both; alu_ctrl=1.
REQ-045 A bench SHALL cover: op=7 -> illegal=1 and done=1 at cycle 1; back in IDLE at cycle 2.
REQ-046 A bench SHALL cover: rst_n=0 during MEM of op=10 -> next cycle all outputs 0 and ready=1; no done pulse.
